// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension divide path: sequencer states,
// funct3 codes, divider op encodings and the drain bound default.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE,
        DRAIN
    } div_state_e;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int DRAIN_CYCLES_DEFAULT = 35;

    function automatic logic [1:0] funct3_to_op(input logic [2:0] f3);
        logic [1:0] op;
        case (f3)
            F3_DIV:  op = OP_DIV;
            F3_DIVU: op = OP_DIVU;
            F3_REM:  op = OP_REM;
            default: op = OP_REMU;
        endcase
        return op;
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Combinational detection of divide-by-zero and signed overflow, with the
// architecturally defined result for those cases.
module div_special_case
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             is_special,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic div_by_zero;
    logic overflow;

    always_comb begin
        div_by_zero = (divisor == '0);
        // Only the signed ops can overflow: most-negative / -1.
        overflow    = op_is_signed(op) && (dividend == MOST_NEG) && (divisor == '1);
        is_special  = div_by_zero || overflow;
        result      = '0;
        if (div_by_zero) begin
            result = op_is_rem(op) ? dividend : '1;
        end else if (overflow) begin
            result = op_is_rem(op) ? '0 : MOST_NEG;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Sequences RV32M divides between the EX stage and a multi-cycle divider:
// zero-latency special cases, stall control, and flush/reset draining.
module div_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             stall,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             div_start,
    output logic [1:0]       div_op,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_f
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    div_state_e       state_q;
    div_state_e       state_d;
    logic [CNT_W-1:0] drain_cnt_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;

    logic             req_div;
    logic             accept;
    logic             capture;
    logic             sc_special;
    logic [WIDTH-1:0] sc_result;

    assign req_div = req_valid && funct3[2];

    // Special cases are judged on the live EX operands so they answer in IDLE.
    div_special_case #(
        .WIDTH (WIDTH)
    ) u_special (
        .op         (funct3_to_op(funct3)),
        .dividend   (rs1_data),
        .divisor    (rs2_data),
        .is_special (sc_special),
        .result     (sc_result)
    );

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_data  = result_q;
        div_start  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_div && !flush) begin
                    if (sc_special) begin
                        resp_valid = 1'b1;
                        resp_data  = sc_result;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                // The start pulse goes out even if flushed; DRAIN then waits for it.
                stall     = 1'b1;
                div_start = 1'b1;
                state_d   = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = div_done ? IDLE : DRAIN;
                end else if (div_done) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = !flush;
                state_d    = IDLE;
            end
            DRAIN: begin
                stall = req_div;
                // Leaving when the count would reach zero bounds DRAIN to DRAIN_CYCLES cycles.
                if (div_done || (drain_cnt_q <= CNT_W'(1))) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = DRAIN;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DRAIN;
            drain_cnt_q <= DRAIN_LOAD;
        end else begin
            state_q <= state_d;
            if (state_q != DRAIN) begin
                drain_cnt_q <= DRAIN_LOAD;
            end else if (drain_cnt_q != '0) begin
                drain_cnt_q <= drain_cnt_q - CNT_W'(1);
            end
        end
    end

    // NOTE: operand and result registers are reset too, so the divider never
    // sees X operands and resp_data is defined from the first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_DIV;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q <= funct3_to_op(funct3);
                a_q  <= rs1_data;
                b_q  <= rs2_data;
            end
            if (capture) begin
                result_q <= div_f;
            end
        end
    end

    // Operands only change on acceptance, so they hold from LAUNCH until div_done.
    assign div_op = op_q;
    assign div_a  = a_q;
    assign div_b  = b_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: a behavioural divider with variable
// latency, directed corner cases, and randomized ops against a reference.
module tb_div_sequencer;
    import muldiv_pkg::*;

    localparam int          DRAIN    = 35;
    localparam logic [31:0] MOST_NEG = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum int { FL_NONE, FL_IDLE, FL_WAIT, FL_DONE } fl_mode_e;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_f;

    always #5 clk = ~clk;

    div_sequencer #(.WIDTH(32), .DRAIN_CYCLES(DRAIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .funct3     (funct3),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .div_start  (div_start),
        .div_op     (div_op),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_f      (div_f)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural RV32M result, straight from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f3[1] ? a : ALL_ONES;
        if (!f3[0] && a == MOST_NEG && b == ALL_ONES) return f3[1] ? 32'd0 : MOST_NEG;
        case (f3[1:0])
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f3[0] && a == MOST_NEG && b == ALL_ONES);
    endfunction

    // Behavioural divider: result computed from the op it was started with,
    // done pulses (L+1) cycles after div_start. Reset also clears it.
    int          force_lat = -1;
    int          last_lat  = 0;
    int          lat_cnt   = 0;
    bit          busy      = 1'b0;
    int          start_cnt = 0;
    int          overlap_cnt = 0;
    int          stable_err  = 0;
    int          stray_tok   = 0;
    int          stray_seen  = 0;
    logic [1:0]  cur_op;
    logic [31:0] cur_a;
    logic [31:0] cur_b;

    initial begin
        div_done = 1'b0;
        div_f    = 32'd0;
    end

    always @(negedge clk) begin
        div_done = 1'b0;
        if (rst) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                if (div_op !== cur_op || div_a !== cur_a || div_b !== cur_b) stable_err++;
                if (lat_cnt == 0) begin
                    div_done = 1'b1;
                    div_f    = ref_div({1'b1, cur_op}, cur_a, cur_b);
                    busy     = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end else if (stray_tok != stray_seen) begin
                stray_seen = stray_tok;
                div_done   = 1'b1;
                div_f      = 32'hDEAD_BEEF;
            end
            if (div_start) begin
                if (busy) overlap_cnt++;
                busy      = 1'b1;
                start_cnt++;
                cur_op    = div_op;
                cur_a     = div_a;
                cur_b     = div_b;
                lat_cnt   = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 29));
                last_lat  = lat_cnt;
            end
        end
    end

    int resp_cnt = 0;
    always @(negedge clk) if (resp_valid) resp_cnt++;

    int exp_resp   = 0;
    int exp_starts = 0;
    int last_pre   = 0;

    task automatic check_totals(input string tag);
        check({tag, "/resp_count"}, 32'(resp_cnt), 32'(exp_resp));
        check({tag, "/start_count"}, 32'(start_cnt), 32'(exp_starts));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            flush     = 1'b0;
            funct3    = 3'b000;
        end
    endtask

    // Presents one instruction in EX and holds it until the pipeline would move on.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input fl_mode_e fm, input int fl_wait,
                          input bit chk_lat, input logic [31:0] exp);
        bit spec;
        bit fin;
        bit do_fl;
        bit started;
        int s0;
        int r0;
        int cyc;
        int waits;
        int pre;
        spec    = is_special(f3, a, b);
        s0      = start_cnt;
        r0      = resp_cnt;
        cyc     = 0;
        waits   = 0;
        pre     = 0;
        fin     = 1'b0;
        do_fl   = 1'b0;
        started = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        funct3    = f3;
        rs1_data  = a;
        rs2_data  = b;
        flush     = (fm == FL_IDLE);
        while (!fin && cyc < 200) begin
            if (do_fl) begin
                @(posedge clk);
                #1;
                flush = 1'b1;
                do_fl = 1'b0;
            end
            @(negedge clk);
            #1;
            cyc++;
            if (flush) begin
                check({tag, "/flushed_resp_valid"}, 32'(resp_valid), 0);
                if (fm == FL_IDLE || fm == FL_DONE) check({tag, "/flushed_stall"}, 32'(stall), 0);
                fin = 1'b1;
            end else if (!stall) begin
                check({tag, "/resp_valid"}, 32'(resp_valid), 1);
                check({tag, "/resp_data"}, resp_data, exp);
                if (chk_lat) check({tag, "/latency"}, 32'(cyc), spec ? 32'd1 : 32'(last_lat + 1 + 3));
                fin = 1'b1;
            end else begin
                if (div_start) begin
                    started = 1'b1;
                    waits   = 0;
                end else if (started) begin
                    waits++;
                end
                if (!started) pre++;
                if (fm == FL_WAIT && started && waits == fl_wait - 1) do_fl = 1'b1;
                if (fm == FL_DONE && div_done) do_fl = 1'b1;
            end
        end
        check({tag, "/completed"}, 32'(fin), 1);
        last_pre = pre;
        if (fm == FL_NONE) exp_resp++;
        if (!spec && fm != FL_IDLE) exp_starts++;
        check({tag, "/resp_delta"}, 32'(resp_cnt - r0), (fm == FL_NONE) ? 32'd1 : 32'd0);
        check({tag, "/start_delta"}, 32'(start_cnt - s0), (spec || fm == FL_IDLE) ? 32'd0 : 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int exp_pre;
        rst       = 1'b1;
        req_valid = 1'b0;
        funct3    = 3'b000;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        flush     = 1'b0;

        // Reset: outputs quiet, stall follows req_valid && funct3[2].
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst/resp_valid", 32'(resp_valid), 0);
        check("rst/div_start", 32'(div_start), 0);
        check("rst/stall_no_req", 32'(stall), 0);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        funct3    = F3_DIV;
        @(negedge clk);
        #1;
        check("rst/stall_div_req", 32'(stall), 1);
        check("rst/resp_valid_req", 32'(resp_valid), 0);
        @(posedge clk);
        #1;
        funct3 = 3'b000;
        @(negedge clk);
        #1;
        check("rst/stall_non_div", 32'(stall), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;

        // DIV 100 / -7 after the reset drain.
        force_lat = 10;
        run_op("div_100_m7_drain", F3_DIV, 32'd100, 32'hFFFF_FFF9, FL_NONE, 0, 1'b0, 32'hFFFF_FFF2);
        check("reset_drain_len_ok", 32'(last_pre >= 2 && last_pre <= DRAIN + 1), 1);
        run_op("div_100_m7", F3_DIV, 32'd100, 32'hFFFF_FFF9, FL_NONE, 0, 1'b1, 32'hFFFF_FFF2);

        // Zero-latency special cases.
        run_op("remu_by0", F3_REMU, 32'h1234_5678, 32'd0, FL_NONE, 0, 1'b1, 32'h1234_5678);
        run_op("divu_by0", F3_DIVU, 32'd5, 32'd0, FL_NONE, 0, 1'b1, ALL_ONES);
        run_op("div_by0", F3_DIV, MOST_NEG, 32'd0, FL_NONE, 0, 1'b1, ALL_ONES);
        run_op("rem_by0", F3_REM, 32'hFFFF_FFF0, 32'd0, FL_NONE, 0, 1'b1, 32'hFFFF_FFF0);
        run_op("div_ovf", F3_DIV, MOST_NEG, ALL_ONES, FL_NONE, 0, 1'b1, MOST_NEG);
        run_op("rem_ovf", F3_REM, MOST_NEG, ALL_ONES, FL_NONE, 0, 1'b1, 32'd0);
        force_lat = 4;
        run_op("divu_min_m1", F3_DIVU, MOST_NEG, ALL_ONES, FL_NONE, 0, 1'b1, 32'd0);
        run_op("remu_min_m1", F3_REMU, MOST_NEG, ALL_ONES, FL_NONE, 0, 1'b1, MOST_NEG);
        idle(2);
        check_totals("specials");

        // Flush in IDLE suppresses both acceptance and the special response.
        run_op("flush_idle_spec", F3_DIV, 32'd7, 32'd0, FL_IDLE, 0, 1'b0, 32'd0);
        run_op("flush_idle_norm", F3_DIVU, 32'd9, 32'd2, FL_IDLE, 0, 1'b0, 32'd0);
        idle(3);
        check_totals("flush_idle");

        // Flush in DONE suppresses resp_valid.
        force_lat = 3;
        run_op("flush_done", F3_DIVU, 32'd100, 32'd7, FL_DONE, 0, 1'b0, 32'd0);
        idle(2);
        check_totals("flush_done");

        // Flush in the 5th WAIT cycle: DRAIN until div_done, then DIVU 9/2.
        force_lat = 20;
        run_op("flush_wait5", F3_DIV, 32'd1000, 32'd3, FL_WAIT, 5, 1'b0, 32'd0);
        run_op("divu_9_2", F3_DIVU, 32'd9, 32'd2, FL_NONE, 0, 1'b0, 32'd4);
        exp_pre = (20 + 1) - 5 + 1;
        check("drain_until_done", 32'(last_pre), 32'(exp_pre));
        idle(2);
        check_totals("flush_wait");

        // Flush coinciding with div_done returns straight to IDLE.
        force_lat = 6;
        run_op("flush_with_done", F3_REM, 32'd50, 32'd7, FL_WAIT, 7, 1'b0, 32'd0);
        run_op("after_flush_done", F3_DIVU, 32'd50, 32'd7, FL_NONE, 0, 1'b1, 32'd7);
        idle(1);
        check_totals("flush_with_done");

        // Stray div_done while idle is ignored.
        stray_tok++;
        idle(3);
        check_totals("stray_done");
        run_op("after_stray", F3_REM, 32'hFFFF_FFF7, 32'd4, FL_NONE, 0, 1'b1, 32'hFFFF_FFFF);

        // Reset asserted during WAIT drops the op; then REM -9/2.
        force_lat = 25;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        funct3    = F3_DIV;
        rs1_data  = 32'd77;
        rs2_data  = 32'd5;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!div_start && k < 10);
        check("rst_wait/launched", 32'(div_start), 1);
        exp_starts++;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_wait/resp_valid", 32'(resp_valid), 0);
        check("rst_wait/div_start", 32'(div_start), 0);
        check("rst_wait/stall", 32'(stall), 1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        force_lat = 8;
        run_op("rem_m9_2", F3_REM, 32'hFFFF_FFF7, 32'd2, FL_NONE, 0, 1'b0, ALL_ONES);
        check("rst_wait/drain_len_ok", 32'(last_pre >= 2 && last_pre <= DRAIN + 1), 1);
        idle(1);
        check_totals("rst_wait");

        // Back-to-back DIVU then REMU.
        force_lat = -1;
        run_op("b2b_divu", F3_DIVU, 32'd10, 32'd3, FL_NONE, 0, 1'b1, 32'd3);
        run_op("b2b_remu", F3_REMU, 32'd10, 32'd3, FL_NONE, 0, 1'b1, 32'd1);
        idle(2);
        check_totals("b2b");

        // Randomized ops with mixed corner operands.
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            int          t;
            f3  = {1'b1, 2'($urandom)};
            sel = int'($urandom_range(0, 5));
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin a = MOST_NEG; b = ALL_ONES; end
                2: begin
                    t = int'($urandom_range(0, 200)) - 100;
                    a = 32'(t);
                    t = int'($urandom_range(1, 20));
                    b = ($urandom_range(0, 1) == 1) ? 32'(-t) : 32'(t);
                end
                default: ;
            endcase
            run_op("rand", f3, a, b, FL_NONE, 0, 1'b1, ref_div(f3, a, b));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);
        check_totals("random");
        check("divider_overlap", 32'(overlap_cnt), 0);
        check("operand_stability", 32'(stable_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 35: upper bound on the divider's busy time, in cycles.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: the EX stage holds a divide instruction.
REQ-006 SHALL have port funct3, input, 3: RV32M op code (100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 SHALL have port rs1_data, input, WIDTH: dividend.
REQ-008 SHALL have port rs2_data, input, WIDTH: divisor.
REQ-009 SHALL have port flush, input, 1: kill the instruction in EX.
REQ-010 SHALL have port stall, output, 1: freeze the pipeline.
REQ-011 SHALL have port resp_valid, output, 1: resp_data is valid this cycle.
REQ-012 SHALL have port resp_data, output, WIDTH: the divide result.
REQ-013 SHALL have ports div_start (out, 1), div_op (out, 2), div_a (out, WIDTH), div_b (out, WIDTH), div_done (in, 1) and div_f (in, WIDTH), which connect to the divider.

Function
REQ-014 SHALL map funct3 to div_op: 100->00, 101->01, 110->10, 111->11.
REQ-015 SHALL ignore req_valid when funct3[2]=0.
REQ-016 SHALL resolve special cases with zero latency when req_valid is high in IDLE: resp_valid=1, stall=0, no div_start.
- Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1_data.
- rs1=0x80000000 and rs2=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
REQ-017 SHALL use the states IDLE, LAUNCH, WAIT, DONE and DRAIN.
REQ-018 In IDLE, a non-special req_valid SHALL register funct3, rs1 and rs2, assert stall, and move to LAUNCH.
REQ-019 In LAUNCH, the block SHALL pulse div_start for exactly 1 cycle with stall=1, then move to WAIT.
REQ-020 In WAIT, the block SHALL keep stall=1; on div_done it SHALL capture div_f into the result register and move to DONE.
REQ-021 In DONE, the block SHALL drive resp_valid=1, stall=0 and resp_data=the result register, then move unconditionally to IDLE; req_valid in DONE SHALL NOT be re-accepted.
REQ-022 div_a, div_b and div_op SHALL come from the registered operands and stay stable from LAUNCH until div_done.
REQ-023 Flush in IDLE SHALL suppress acceptance and the special-case response.
REQ-024 Flush in DONE SHALL suppress resp_valid.
REQ-025 Flush in LAUNCH or WAIT SHALL move to DRAIN with no response, because the divider cannot abort.
REQ-026 Flush and div_done in the same WAIT cycle SHALL move to IDLE with no response.
REQ-027 On entry to DRAIN, the block SHALL load a down-counter with DRAIN_CYCLES.
REQ-028 DRAIN SHALL exit to IDLE on div_done or when the counter reaches 0.
REQ-029 In DRAIN, stall SHALL equal req_valid && funct3[2].
REQ-030 div_done seen in IDLE or DONE SHALL be ignored.
REQ-031 Total latency of a non-special divide SHALL be divider latency + 3 cycles of stall (IDLE accept, LAUNCH, DONE).

Reset
REQ-032 Reset SHALL force state=DRAIN, drain counter=DRAIN_CYCLES, result register=0 and the operand registers=0.
REQ-033 In reset, outputs SHALL be resp_valid=0 and div_start=0, with stall following REQ-029; reset covers a divider left busy.
REQ-034 Reset asserted mid-operation SHALL drop the operation with no response.

Structure
REQ-035 A shared package muldiv_pkg SHALL hold the state enum, the funct3 constants, the div_op encodings and the DRAIN_CYCLES default.
REQ-036 A combinational sub-module div_special_case SHALL detect divide-by-zero and signed overflow and produce the special result.

Verification
REQ-037 After reset drain, DIV 100/-7 SHALL give 1 stall-free special-free run, 1 div_start pulse, stall high until DONE, then resp_data=0xFFFFFFF2 (-14) for exactly 1 cycle.
REQ-038 REMU 0x12345678/0 SHALL give resp_valid in the same cycle, resp_data=0x12345678, stall=0 and no div_start.
REQ-039 DIV 0x80000000/0xFFFFFFFF SHALL give 0x80000000 with zero latency; REM on the same operands SHALL give 0.
REQ-040 Flush in the 5th WAIT cycle SHALL give DRAIN, no resp_valid, and IDLE after div_done; a following DIVU 9/2 SHALL return 4.
REQ-041 Reset asserted during WAIT and released SHALL give DRAIN for at most 35 cycles; a following REM -9/2 SHALL return 0xFFFFFFFF.
REQ-042 Back-to-back DIVU 10/3 then REMU 10/3 SHALL return 3 then 1, each with exactly 1 resp_valid and no duplicate acceptance.
